// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory bus bundle for mem_access_ctrl.
interface mem_access_ctrl_if;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;

   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic          req_byte;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   // Controller side
   modport master (
      input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_addr, mem_rd, mem_wr, mem_wdata, busy
   );

   // CPU control unit and memory side
   modport slave (
      output req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_addr, mem_rd, mem_wr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store bus initiator in front of a big-endian, byte-addressed word memory.
// Byte loads extract a lane; byte stores do read-modify-write.
module mem_access_ctrl #(
   parameter int unsigned READ_LAT      = 1,
   parameter bit          SIGN_EXT_BYTE = 1'b0,
   parameter logic [15:0] ADDR_LIMIT    = 16'hFFFF
) (
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.master bus
);
   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 16;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             we_q, we_d;
   logic             byte_q, byte_d;
   logic             lsb_q, lsb_d;
   logic [7:0]       wbyte_q, wbyte_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_rd_q, mem_rd_d;
   logic             mem_wr_q, mem_wr_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q, rsp_err_d;
   logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;

   logic             req_err;
   logic [7:0]       lane;
   logic [DW-1:0]    lane_ext;
   logic [DW-1:0]    merged;

   // Request check and big-endian lane handling of the returned word
   always_comb begin
      req_err  = (!bus.req_byte && bus.req_addr[0]) || (bus.req_addr > ADDR_LIMIT);
      lane     = lsb_q ? bus.mem_rdata[7:0] : bus.mem_rdata[15:8];
      lane_ext = SIGN_EXT_BYTE ? {{8{lane[7]}}, lane} : {8'h00, lane};
      merged   = lsb_q ? {bus.mem_rdata[15:8], wbyte_q} : {wbyte_q, bus.mem_rdata[7:0]};
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         byte_q      <= 1'b0;
         lsb_q       <= 1'b0;
         wbyte_q     <= 8'h00;
         cnt_q       <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         byte_q      <= byte_d;
         lsb_q       <= lsb_d;
         wbyte_q     <= wbyte_d;
         cnt_q       <= cnt_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Next state; strobes and the response are computed one edge ahead so they leave flops
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      byte_d      = byte_q;
      lsb_d       = lsb_q;
      wbyte_d     = wbyte_q;
      cnt_d       = cnt_q;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               byte_d  = bus.req_byte;
               lsb_d   = bus.req_addr[0];
               wbyte_d = bus.req_wdata[7:0];
               if (req_err) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else if (bus.req_we && !bus.req_byte) begin
                  state_d     = WR;
                  mem_wr_d    = 1'b1;
                  mem_addr_d  = {bus.req_addr[AW-1:1], 1'b0};
                  mem_wdata_d = bus.req_wdata;
               end else begin
                  state_d    = RD;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = {bus.req_addr[AW-1:1], 1'b0};
               end
            end
         end
         RD: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(READ_LAT);
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // The edge that takes the counter to zero is the capture edge
            if (cnt_q == CNT_W'(1)) begin
               if (we_q) begin
                  state_d     = WR;
                  mem_wr_d    = 1'b1;
                  mem_wdata_d = merged;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = byte_q ? lane_ext : bus.mem_rdata;
               end
            end
         end
         WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Port drive
   always_comb begin
      bus.req_ready = (state_q == IDLE) && !rst;
      bus.busy      = (state_q != IDLE);
      bus.mem_rd    = mem_rd_q;
      bus.mem_wr    = mem_wr_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.rsp_valid = rsp_valid_q;
      bus.rsp_err   = rsp_err_q;
      bus.rsp_rdata = rsp_rdata_q;
   end
endmodule
